cvxif_copro_responder: RTL and testbench

Coprocessor-side responder for the CV-X-IF extension interface, which is enabled in the CVA6 core configuration. The core is the initiator and this block is the responder. It decodes custom-3 instructions offered on the issue channel and accepts or rejects them. Accepted instructions are computed immediately and held in an in-order pending buffer until the core commits or kills them. Committed results are returned on the result channel in issue order.

---
 rtl/cvxif_copro_pkg.sv | 28 ++
 rtl/cvxif_copro_responder_if.sv | 42 ++++
 rtl/cvxif_copro_alu.sv | 47 ++++
 rtl/cvxif_copro_responder.sv | 104 ++++++++++
 tb/tb_cvxif_copro_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF custom-3 coprocessor responder.
package cvxif_copro_pkg;

   localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;

   typedef enum logic [2:0] {
      CADD = 3'b000,
      CXOR = 3'b001,
      CNOP = 3'b010,
      CROT = 3'b011
   } funct3_e;

   typedef enum logic [1:0] {
      FREE      = 2'd0,
      PENDING   = 2'd1,
      COMMITTED = 2'd2,
      KILLED    = 2'd3
   } entry_state_t;

   // Control part of a pending-buffer entry; id and data live in
   // parameter-sized arrays next to it in the top.
   typedef struct packed {
      entry_state_t state;
      logic [4:0]   rd;
      logic         we;
   } entry_t;

endpackage

// File: rtl/cvxif_copro_responder_if.sv
// CV-X-IF issue / commit / result channels between the core (master)
// and the coprocessor responder (slave).
interface cvxif_copro_responder_if #(
   parameter int XLEN     = 32,
   parameter int ID_WIDTH = 3
);
   logic                issue_valid_i;
   logic                issue_ready_o;
   logic [31:0]         issue_instr_i;
   logic [XLEN-1:0]     issue_rs1_i;
   logic [XLEN-1:0]     issue_rs2_i;
   logic [ID_WIDTH-1:0] issue_id_i;
   logic                issue_accept_o;
   logic                issue_writeback_o;

   logic                commit_valid_i;
   logic [ID_WIDTH-1:0] commit_id_i;
   logic                commit_kill_i;

   logic                result_valid_o;
   logic                result_ready_i;
   logic [ID_WIDTH-1:0] result_id_o;
   logic [XLEN-1:0]     result_data_o;
   logic [4:0]          result_rd_o;
   logic                result_we_o;

   modport master (
      output issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i, issue_id_i,
      input  issue_ready_o, issue_accept_o, issue_writeback_o,
      output commit_valid_i, commit_id_i, commit_kill_i,
      input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
      output result_ready_i
   );

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_rs1_i, issue_rs2_i, issue_id_i,
      output issue_ready_o, issue_accept_o, issue_writeback_o,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
      input  result_ready_i
   );
endinterface

// File: rtl/cvxif_copro_alu.sv
// Combinational decode and compute for custom-3 instructions.
// CVXIF_COPRO_ROT_EN: when defined, funct3 011 (CROT) is decoded and the
// rotator is built; otherwise that encoding is illegal.
module cvxif_copro_alu
   import cvxif_copro_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            legal,
   output logic            we,
   output logic [XLEN-1:0] result
);

   // Upper instruction bits carry no information for these encodings.
   logic unused_instr_hi;
   assign unused_instr_hi = ^instr[31:15];

`ifdef CVXIF_COPRO_ROT_EN
   // Rotate-left: shift a doubled copy and keep the upper half.
   logic [2*XLEN-1:0] rot_dbl;
   logic [XLEN-1:0]   rot;
   assign rot_dbl = {rs1, rs1} << rs2[4:0];
   assign rot     = rot_dbl[2*XLEN-1 -: XLEN];
`endif

   // Decode opcode/funct3 and produce the result in the same cycle.
   always_comb begin
      legal  = 1'b0;
      we     = 1'b0;
      result = '0;
      if (instr[6:0] == OPCODE_CUSTOM3) begin
         case (funct3_e'(instr[14:12]))
            CADD: begin legal = 1'b1; we = 1'b1; result = rs1 + rs2; end
            CXOR: begin legal = 1'b1; we = 1'b1; result = rs1 ^ rs2; end
            CNOP: begin legal = 1'b1; end
`ifdef CVXIF_COPRO_ROT_EN
            CROT: begin legal = 1'b1; we = 1'b1; result = rot; end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: accepts custom-3 instructions, computes
// them at issue, parks them in an in-order buffer until commit/kill and
// returns committed results in issue order.
// CVXIF_COPRO_ROT_EN: enables the CROT instruction (see cvxif_copro_alu).
module cvxif_copro_responder
   import cvxif_copro_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ID_WIDTH = 3,
   parameter int DEPTH    = 4
) (
   input logic                     clk_i,
   input logic                     rst_i,
   cvxif_copro_responder_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t              ent_q  [DEPTH];
   logic [ID_WIDTH-1:0] id_q   [DEPTH];
   logic [XLEN-1:0]     data_q [DEPTH];
   logic [PTR_W-1:0]    head_q, tail_q;
   logic [PTR_W:0]      count_q;

   logic             alu_legal, alu_we;
   logic [XLEN-1:0]  alu_result;
   logic [DEPTH-1:0] id_clash, commit_hit;
   logic             full, accept, head_commit, head_kill, pop;

   cvxif_copro_alu #(.XLEN(XLEN)) u_alu (
      .instr  (bus.issue_instr_i),
      .rs1    (bus.issue_rs1_i),
      .rs2    (bus.issue_rs2_i),
      .legal  (alu_legal),
      .we     (alu_we),
      .result (alu_result)
   );

   // CAM over the buffer: live-id clash for issue, PENDING match for commit.
   always_comb begin
      id_clash   = '0;
      commit_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         id_clash[i]   = (ent_q[i].state != FREE) && (id_q[i] == bus.issue_id_i);
         commit_hit[i] = bus.commit_valid_i && (ent_q[i].state == PENDING) &&
                         (id_q[i] == bus.commit_id_i);
      end
   end

   assign full   = (count_q == (PTR_W+1)'(DEPTH));
   assign accept = bus.issue_valid_i & ~full & alu_legal & ~|id_clash & ~rst_i;

   assign bus.issue_ready_o     = ~full;
   assign bus.issue_accept_o    = accept;
   assign bus.issue_writeback_o = accept & alu_we;

   assign head_commit = (ent_q[head_q].state == COMMITTED);
   assign head_kill   = (ent_q[head_q].state == KILLED);
   assign pop         = (head_commit & bus.result_ready_i) | head_kill;

   // Result fields are zero unless a committed head is being presented.
   assign bus.result_valid_o = head_commit;
   assign bus.result_id_o    = head_commit ? id_q[head_q]   : '0;
   assign bus.result_data_o  = head_commit ? data_q[head_q] : '0;
   assign bus.result_rd_o    = head_commit ? ent_q[head_q].rd : '0;
   assign bus.result_we_o    = head_commit & ent_q[head_q].we;

   // Buffer state: commit/kill marking, head pop, tail push, occupancy.
   // Commit never hits the popped head (not PENDING) nor the pushed tail
   // (FREE), so the three updates touch distinct entries.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i]  <= '{state: FREE, rd: '0, we: 1'b0};
            id_q[i]   <= '0;
            data_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_hit[i])
               ent_q[i].state <= bus.commit_kill_i ? KILLED : COMMITTED;
         end
         if (pop) begin
            ent_q[head_q].state <= FREE;
            head_q              <= head_q + 1'b1;
         end
         if (accept) begin
            ent_q[tail_q]  <= '{state: PENDING, rd: bus.issue_instr_i[11:7], we: alu_we};
            id_q[tail_q]   <= bus.issue_id_i;
            data_q[tail_q] <= alu_result;
            tail_q         <= tail_q + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Bench for cvxif_copro_responder: directed scenarios plus random traffic
// against a queue-based reference model; results go through a scoreboard.
module tb_cvxif_copro_responder;

   localparam int XLEN  = 32;
   localparam int IDW   = 3;
   localparam int DEPTH = 4;

   logic clk, rst_i;

   cvxif_copro_responder_if #(.XLEN(XLEN), .ID_WIDTH(IDW)) bus ();

   cvxif_copro_responder #(.XLEN(XLEN), .ID_WIDTH(IDW), .DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // st: 0 = pending, 1 = committed, 2 = killed
   typedef struct {
      logic [IDW-1:0]  id;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      bit              we;
      int              st;
   } ment_t;

   ment_t mq[$];     // entries the responder still holds, oldest first
   ment_t expq[$];   // results expected on the result channel

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {17'd0, f3, rd, opc};
   endfunction

   // Instruction semantics written straight from the ISA description.
   function automatic void ref_exec(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                    output bit legal, output bit we, output logic [31:0] r);
      legal = 0; we = 0; r = 0;
      if (instr[6:0] != 7'h7b) return;
      case (instr[14:12])
         3'd0: begin legal = 1; we = 1; r = a + b; end
         3'd1: begin legal = 1; we = 1; r = a ^ b; end
         3'd2: begin legal = 1; end
`ifdef CVXIF_COPRO_ROT_EN
         3'd3: begin
            legal = 1; we = 1; r = a;
            for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
         end
`endif
         default: ;
      endcase
   endfunction

   // One clock of stimulus; checks issue/handshake outputs against the
   // model, queues any result that should be taken, then advances the model.
   task automatic cyc(input bit iv, input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                      input logic [IDW-1:0] id, input bit cv, input logic [IDW-1:0] cid,
                      input bit ck, input bit rr);
      bit legal, we, full, dup, acc, hv, hk;
      logic [31:0] r;
      ment_t e;
      @(posedge clk); #1;
      bus.issue_valid_i  = iv;
      bus.issue_instr_i  = instr;
      bus.issue_rs1_i    = a;
      bus.issue_rs2_i    = b;
      bus.issue_id_i     = id;
      bus.commit_valid_i = cv;
      bus.commit_id_i    = cid;
      bus.commit_kill_i  = ck;
      bus.result_ready_i = rr;
      #1;
      ref_exec(instr, a, b, legal, we, r);
      full = (mq.size() == DEPTH);
      dup  = 0;
      foreach (mq[i]) if (mq[i].id == id) dup = 1;
      acc = iv && !full && legal && !dup;
      hv  = (mq.size() > 0) && (mq[0].st == 1);
      hk  = (mq.size() > 0) && (mq[0].st == 2);
      chk("issue_ready", bus.issue_ready_o, !full);
      chk("issue_accept", bus.issue_accept_o, acc);
      chk("issue_writeback", bus.issue_writeback_o, acc && we);
      chk("result_valid", bus.result_valid_o, hv);
      if (hv && rr) expq.push_back(mq[0]);
      if (cv) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].st == 0 && mq[i].id == cid) begin
               e = mq[i]; e.st = ck ? 2 : 1; mq[i] = e;
               break;
            end
         end
      end
      if ((hv && rr) || hk) void'(mq.pop_front());
      if (acc) begin
         e.id = id; e.rd = instr[11:7]; e.data = r; e.we = we; e.st = 0;
         mq.push_back(e);
      end
   endtask

   task automatic idle(input int n, input bit rr);
      repeat (n) cyc(0, 32'd0, 32'd0, 32'd0, '0, 0, '0, 0, rr);
   endtask

   task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [IDW-1:0] id, input bit rr);
      cyc(1, mk(f3, rd, 7'h7b), a, b, id, 0, '0, 0, rr);
   endtask

   task automatic commit(input logic [IDW-1:0] cid, input bit ck, input bit rr);
      cyc(0, 32'd0, 32'd0, 32'd0, '0, 1, cid, ck, rr);
   endtask

   // Scoreboard monitor: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_i === 1'b0 && bus.result_valid_o === 1'b1 && bus.result_ready_i === 1'b1) begin
         ment_t e;
         if (expq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected: got result id %0d, expected none", bus.result_id_o);
         end else begin
            e = expq.pop_front();
            chk("sb_id", bus.result_id_o, e.id);
            chk("sb_data", bus.result_data_o, e.data);
            chk("sb_rd", bus.result_rd_o, e.rd);
            chk("sb_we", bus.result_we_o, e.we);
         end
      end
   end

   initial begin
      bit       iv, cv, ck, rr, found;
      logic [2:0] f3;
      logic [6:0] opc;
      logic [IDW-1:0] id, cid;

      rst_i = 1'b1;
      bus.issue_valid_i = 0; bus.issue_instr_i = 0; bus.issue_rs1_i = 0; bus.issue_rs2_i = 0;
      bus.issue_id_i = 0; bus.commit_valid_i = 0; bus.commit_id_i = 0; bus.commit_kill_i = 0;
      bus.result_ready_i = 0;
      #3;
      chk("rst_issue_ready", bus.issue_ready_o, 1'b1);
      chk("rst_result_valid", bus.result_valid_o, 1'b0);
      chk("rst_accept", bus.issue_accept_o, 1'b0);
      chk("rst_writeback", bus.issue_writeback_o, 1'b0);
      chk("rst_result_data", bus.result_data_o, 32'd0);
      @(posedge clk); #1; rst_i = 1'b0;

      // CADD wraps modulo 2^32
      issue(3'b000, 5'd5, 32'hFFFF_FFFF, 32'd2, 3'd1, 1);
      commit(3'd1, 0, 1);
      idle(1, 1);
      chk("cadd_wrap_data", bus.result_data_o, 32'h1);
      idle(1, 1);

      // wrong opcode rejected; later commit of its id is ignored
      cyc(1, mk(3'b000, 5'd3, 7'h33), 32'd7, 32'd8, 3'd3, 0, '0, 0, 1);
      commit(3'd3, 0, 1);
      idle(2, 1);

      // kill the oldest; the other two retire in order
      issue(3'b001, 5'd1, 32'h1234_5678, 32'h0F0F_0F0F, 3'd0, 1);
      issue(3'b001, 5'd2, 32'hDEAD_BEEF, 32'hFFFF_0000, 3'd1, 1);
      issue(3'b001, 5'd3, 32'h0000_00FF, 32'h0000_0F0F, 3'd2, 1);
      commit(3'd0, 1, 1);
      commit(3'd1, 0, 1);
      commit(3'd2, 0, 1);
      idle(4, 1);

      // fill, back-pressure, drain one, duplicate id rejection
      for (int i = 0; i < 4; i++) issue(3'b000, 5'(i + 8), 32'(i * 3), 32'd100, 3'(i), 1);
      issue(3'b000, 5'd20, 32'd1, 32'd1, 3'd5, 1);
      commit(3'd0, 0, 1);
      idle(1, 1);
      issue(3'b001, 5'd21, 32'd9, 32'd9, 3'd2, 1);
      commit(3'd1, 0, 1);
      commit(3'd2, 0, 1);
      commit(3'd3, 0, 1);
      idle(4, 1);

      // committed head held under back-pressure, then async reset
      issue(3'b001, 5'd17, 32'hA5A5_0000, 32'h0F0F_F0F0, 3'd6, 0);
      commit(3'd6, 0, 0);
      for (int k = 0; k < 5; k++) begin
         idle(1, 0);
         chk("hold_data", bus.result_data_o, 32'hAAAA_F0F0);
         chk("hold_id", bus.result_id_o, 3'd6);
         chk("hold_rd", bus.result_rd_o, 5'd17);
      end
      @(posedge clk); #1;
      rst_i = 1'b1;
      #1;
      chk("midrst_result_valid", bus.result_valid_o, 1'b0);
      chk("midrst_issue_ready", bus.issue_ready_o, 1'b1);
      chk("midrst_result_data", bus.result_data_o, 32'd0);
      mq.delete();
      expq.delete();
      @(posedge clk); #1; rst_i = 1'b0;
      idle(2, 1);

      // CROT: only legal when the rotator is built
      cyc(1, mk(3'b011, 5'd9, 7'h7b), 32'h8000_0001, 32'd1, 3'd1, 0, '0, 0, 1);
      commit(3'd1, 0, 1);
      idle(1, 1);
`ifdef CVXIF_COPRO_ROT_EN
      chk("crot_data", bus.result_data_o, 32'h3);
`else
      chk("crot_absent", bus.result_valid_o, 1'b0);
`endif
      idle(2, 1);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         iv  = ($urandom_range(0, 1) == 1);
         f3  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         opc = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h7b;
         id  = 3'($urandom_range(0, 7));
         cv  = ($urandom_range(0, 9) < 4);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            cid = mq[$urandom_range(0, mq.size() - 1)].id;
         else
            cid = 3'($urandom_range(0, 7));
         ck  = ($urandom_range(0, 3) == 0);
         rr  = ($urandom_range(0, 9) < 7);
         cyc(iv, mk(f3, 5'($urandom_range(0, 31)), opc), $urandom, $urandom, id, cv, cid, ck, rr);
      end

      // drain: retire everything still pending
      for (int n = 0; n < 24; n++) begin
         found = 0; cid = '0;
         foreach (mq[i]) if (!found && mq[i].st == 0) begin found = 1; cid = mq[i].id; end
         cyc(0, 32'd0, 32'd0, 32'd0, '0, found, cid, 0, 1);
      end
      idle(4, 1);
      chk("sb_drained", 64'(expq.size()), 64'd0);
      chk("model_drained", 64'(mq.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
